// File: rtl/tft_pic_buf_if.sv
// Pixel and byte-stream bundle between the TFT side and the frame buffer.
// The master drives received bytes and pixel coordinates; the slave returns
// the pixel colour and the image-loaded flag.
interface tft_pic_buf_if;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_data;
    logic       pic_done;

    modport master (
        output pi_data, pi_flag, pix_x, pix_y,
        input  pix_data, pic_done
    );

    modport slave (
        input  pi_data, pi_flag, pix_x, pix_y,
        output pix_data, pic_done
    );
endinterface

// File: rtl/tft_pic_buf.sv
// Frame buffer for the TFT controller: a PIC_W x PIC_H RGB332 image is
// written byte by byte from the serial receiver and read back, centred on
// the panel, one clock after each pixel coordinate is requested.
module tft_pic_buf #(
    parameter int         H_VALID  = 480,
    parameter int         V_VALID  = 272,
    parameter int         PIC_W    = 100,
    parameter int         PIC_H    = 100,
    parameter logic [7:0] BG_COLOR = 8'hFF,
    parameter int         ADDR_W   = 14
) (
    input  logic          tft_clk_9m,
    input  logic          sys_rst_n,
    tft_pic_buf_if.slave  bus
);
    localparam int                NPIX      = PIC_W * PIC_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [9:0]        X0        = 10'((H_VALID - PIC_W) / 2);
    localparam logic [9:0]        X1        = 10'((H_VALID - PIC_W) / 2 + PIC_W - 1);
    localparam logic [9:0]        Y0        = 10'((V_VALID - PIC_H) / 2);
    localparam logic [9:0]        Y1        = 10'((V_VALID - PIC_H) / 2 + PIC_H - 1);

    logic [7:0]        mem_q [0:(2**ADDR_W)-1];
    logic [7:0]        ram_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pic_done_q, pic_done_d;
    logic              in_win_q;
    logic              run_q;
    logic              in_win;

    // The blanking code 10'h3FF is above X1/Y1, so it never lands in the window.
    assign in_win = (bus.pix_x >= X0) && (bus.pix_x <= X1) &&
                    (bus.pix_y >= Y0) && (bus.pix_y <= Y1);

    // Write pointer: wraps after the last pixel and marks the image as loaded.
    always_comb begin
        wr_addr_d  = wr_addr_q;
        pic_done_d = pic_done_q;
        if (bus.pi_flag) begin
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d  = '0;
                pic_done_d = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // Read pointer: restarts at the top-left panel pixel, advances per window pixel.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (bus.pix_x == 10'd0 && bus.pix_y == 10'd0) begin
            rd_addr_d = '0;
        end else if (in_win) begin
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
        end
    end

    // Control state; run_q holds the output at zero until the first clock out of reset.
    always_ff @(posedge tft_clk_9m) begin
        if (!sys_rst_n) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            pic_done_q <= 1'b0;
            in_win_q   <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            pic_done_q <= pic_done_d;
            in_win_q   <= in_win;
            run_q      <= 1'b1;
        end
    end

    // Image RAM, read-first: a read of the address being written sees the old byte.
    always_ff @(posedge tft_clk_9m) begin
        if (bus.pi_flag) begin
            mem_q[wr_addr_q] <= bus.pi_data;
        end
        if (in_win) begin
            ram_q <= mem_q[rd_addr_q];
        end
    end

    assign bus.pix_data = !run_q                    ? 8'h00 :
                          (in_win_q && pic_done_q)  ? ram_q : BG_COLOR;
    assign bus.pic_done = pic_done_q;
endmodule

// File: tb/tb_tft_pic_buf.sv
// Directed bench for the TFT frame buffer: reset behaviour, image load,
// windowed raster read-back, read-first collision and reset mid-load.
module tb_tft_pic_buf;
    logic clk;
    logic rst_n;
    tft_pic_buf_if bus ();

    tft_pic_buf dut (
        .tft_clk_9m (clk),
        .sys_rst_n  (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] exp;
    } probe_t;

    probe_t     tbl [8];
    logic [7:0] img [10000];
    int         wcount;
    bit         mdone;
    int         errors;
    int         checks;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.pi_flag = 1'b1;
        bus.pi_data = d;
        step();
        img[wcount] = d;
        wcount = (wcount + 1) % 10000;
        if (wcount == 0) mdone = 1'b1;
    endtask

    function automatic logic [7:0] model(input int x, input int y);
        if (mdone && x >= 190 && x <= 289 && y >= 86 && y <= 185)
            return img[(y - 86) * 100 + (x - 190)];
        return 8'hFF;
    endfunction

    // One frame: start-of-frame pixel, then the window area plus a 1-pixel border.
    task automatic scan_frame(input bit use_tbl);
        bus.pi_flag = 1'b0;
        bus.pix_x = 10'd0;
        bus.pix_y = 10'd0;
        step();
        check("sof_pixel", bus.pix_data, 8'hFF);
        for (int y = 85; y <= 186; y++) begin
            for (int x = 189; x <= 290; x++) begin
                bus.pix_x = 10'(x);
                bus.pix_y = 10'(y);
                step();
                if (bus.pix_data !== model(x, y)) begin
                    $display("FAIL pixel(%0d,%0d): got %02h expected %02h", x, y, bus.pix_data, model(x, y));
                    errors++;
                end
                checks++;
                if (use_tbl) begin
                    for (int k = 0; k < 8; k++) begin
                        if (tbl[k].x == 10'(x) && tbl[k].y == 10'(y))
                            check(tbl[k].name, bus.pix_data, tbl[k].exp);
                    end
                end
            end
        end
        bus.pix_x = 10'h3FF;
        bus.pix_y = 10'h3FF;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        wcount = 0;
        mdone  = 1'b0;
        tbl[0] = '{"win_first",     10'd190, 10'd86,  8'h00};
        tbl[1] = '{"win_second",    10'd191, 10'd86,  8'h01};
        tbl[2] = '{"win_row1",      10'd190, 10'd87,  8'h64};
        tbl[3] = '{"win_last",      10'd289, 10'd185, 8'h0F};
        tbl[4] = '{"left_of_win",   10'd189, 10'd86,  8'hFF};
        tbl[5] = '{"right_of_win",  10'd290, 10'd185, 8'hFF};
        tbl[6] = '{"row0_end",      10'd289, 10'd86,  8'h63};
        tbl[7] = '{"last_row_head", 10'd190, 10'd185, 8'hAC};

        rst_n       = 1'b0;
        bus.pi_flag = 1'b0;
        bus.pi_data = 8'h00;
        bus.pix_x   = 10'h3FF;
        bus.pix_y   = 10'h3FF;
        step();
        step();
        check("reset_pix_data", bus.pix_data, 8'h00);
        check("reset_pic_done", {7'd0, bus.pic_done}, 8'h00);

        // Test 1: first clock out of reset in blanking
        rst_n = 1'b1;
        step();
        check("blank_pix_data", bus.pix_data, 8'hFF);
        check("blank_pic_done", {7'd0, bus.pic_done}, 8'h00);

        // Window before any image is loaded shows background
        bus.pix_x = 10'd0; bus.pix_y = 10'd0; step();
        bus.pix_x = 10'd190; bus.pix_y = 10'd86; step();
        check("unloaded_window", bus.pix_data, 8'hFF);
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF; step();

        // Test 2: load image, value = addr[7:0]
        for (int i = 0; i < 10000; i++) begin
            send_byte(8'(i));
            if (i == 0)    check("done_after_first", {7'd0, bus.pic_done}, 8'h00);
            if (i == 9998) check("done_before_last", {7'd0, bus.pic_done}, 8'h00);
            if (i == 9999) check("done_after_last",  {7'd0, bus.pic_done}, 8'h01);
        end
        bus.pi_flag = 1'b0;

        // Tests 3 and 4: two consecutive frames
        scan_frame(1'b1);
        scan_frame(1'b1);
        check("done_sticky", {7'd0, bus.pic_done}, 8'h01);

        // Test 5: write address 0 while reading address 0
        bus.pix_x = 10'd0; bus.pix_y = 10'd0; step();
        bus.pix_x = 10'd190; bus.pix_y = 10'd86;
        bus.pi_flag = 1'b1; bus.pi_data = 8'hAA;
        step();
        bus.pi_flag = 1'b0;
        check("read_first_old", bus.pix_data, 8'h00);
        img[0] = 8'hAA;
        wcount = 1;
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF; step();
        scan_frame(1'b0);
        check("addr0_new_value", img[0], 8'hAA);

        // Test 6: reset part-way through a load
        for (int i = 0; i < 5000; i++) send_byte(8'(i * 3));
        bus.pi_flag = 1'b0;
        rst_n = 1'b0;
        step();
        check("midreset_pix_data", bus.pix_data, 8'h00);
        check("midreset_pic_done", {7'd0, bus.pic_done}, 8'h00);
        wcount = 0;
        mdone  = 1'b0;
        rst_n  = 1'b1;
        step();
        check("post_reset_blank", bus.pix_data, 8'hFF);
        for (int i = 0; i < 10000; i++) begin
            send_byte(8'(i * 7 + 1));
            if (i == 9998) check("reload_done_before", {7'd0, bus.pic_done}, 8'h00);
            if (i == 9999) check("reload_done_after",  {7'd0, bus.pic_done}, 8'h01);
        end
        bus.pi_flag = 1'b0;
        scan_frame(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
